// File: rtl/blaster_pulse_scheduler.sv
// blaster_pulse_scheduler: round-robin sharing of one pulse-length down-counter
// between N_CH requesters. Single-cycle strobes are queued (one pending slot per
// channel). A registered pulse is then issued with a per-channel length, and a
// guard gap follows each pulse.
//   i_clk, i_rst_n (async, active-low), i_req[N_CH], i_len[N_CH*BIT_WIDTH],
//   i_ovf_clr -> o_pulse[N_CH], o_busy, o_pend[N_CH], o_ovf[N_CH]
// Optional: BLASTER_PULSE_RETRIGGER_EN. A request from the active channel
// reloads the counter instead of queueing.
module blaster_pulse_scheduler #(
  parameter int N_CH      = 4,
  parameter int BIT_WIDTH = 6,
  parameter int GAP_CYC   = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_CH-1:0]           i_req,
  input  logic [N_CH*BIT_WIDTH-1:0] i_len,
  input  logic                      i_ovf_clr,
  output logic [N_CH-1:0]           o_pulse,
  output logic                      o_busy,
  output logic [N_CH-1:0]           o_pend,
  output logic [N_CH-1:0]           o_ovf
);

  localparam int PW         = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int GAP_LOAD_I = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [BIT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [3:0]            gap_q, gap_d;
  logic [N_CH-1:0]       pend_q, pend_d;
  logic [N_CH-1:0]       ovf_q, ovf_d;
  logic [N_CH-1:0]       pulse_q, pulse_d;
  logic                  busy_q, busy_d;

  logic [BIT_WIDTH-1:0]  len_arr [N_CH];
  logic [PW-1:0]         grant;
  logic                  grant_vld;
  logic [N_CH-1:0]       pend_clr;
  logic [N_CH-1:0]       retrig;
  logic [N_CH-1:0]       req_eff;
  logic [N_CH-1:0]       ovf_set;

  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      len_arr[k] = i_len[k*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  // First pending channel strictly after ptr, wrapping modulo N_CH.
  always_comb begin : p_grant
    logic [PW-1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      idx = PW'((32'(ptr_q) + i) % 32'(N_CH));
      if (!grant_vld && pend_q[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    pend_clr = '0;
    if (state_q == ST_IDLE && grant_vld) begin
      pend_clr[grant] = 1'b1;
    end
  end

`ifdef BLASTER_PULSE_RETRIGGER_EN
  always_comb begin
    retrig = '0;
    if (state_q == ST_ACTIVE) begin
      retrig[ptr_q] = i_req[ptr_q];
    end
  end
`else
  assign retrig = '0;
`endif

  // Set beats clear on both the pending latch and the overflow flag.
  assign req_eff = i_req & ~retrig;
  assign pend_d  = (pend_q & ~pend_clr) | req_eff;
  assign ovf_set = req_eff & pend_q & ~pend_clr;
  assign ovf_d   = (i_ovf_clr ? '0 : ovf_q) | ovf_set;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    pulse_d = pulse_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d        = ST_ACTIVE;
          pulse_d        = '0;
          pulse_d[grant] = 1'b1;
          cnt_d          = len_arr[grant];
          ptr_d          = grant;
        end
      end
      ST_ACTIVE: begin
        if (|retrig) begin
          cnt_d = len_arr[ptr_q];
        end else if (cnt_q == '0) begin
          pulse_d = '0;
          if (GAP_CYC > 0) begin
            state_d = ST_GAP;
            gap_d   = 4'(GAP_LOAD_I);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pulse_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(N_CH - 1);
      cnt_q   <= '0;
      gap_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      pulse_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign o_pulse = pulse_q;
  assign o_busy  = busy_q;
  assign o_pend  = pend_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_blaster_pulse_scheduler.sv
module tb_blaster_pulse_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [23:0] len;
  logic        ovf_clr;
  logic [3:0]  pulse;
  logic        busy;
  logic [3:0]  pend;
  logic [3:0]  ovf;

  int checks = 0;
  int errors = 0;

  blaster_pulse_scheduler #(
    .N_CH      (4),
    .BIT_WIDTH (6),
    .GAP_CYC   (1)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_len     (len),
    .i_ovf_clr (ovf_clr),
    .o_pulse   (pulse),
    .o_busy    (busy),
    .o_pend    (pend),
    .o_ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [3:0] e_pulse, input logic e_busy,
                      input logic [3:0] e_pend);
    chk({tag, ".pulse"}, 32'(pulse), 32'(e_pulse));
    chk({tag, ".busy"},  32'(busy),  32'(e_busy));
    chk({tag, ".pend"},  32'(pend),  32'(e_pend));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    len     = '0;
    ovf_clr = 1'b0;

    // Reset state
    tick();
    chk3("rst", 4'b0000, 1'b0, 4'b0000);
    chk("rst.ovf", 32'(ovf), 32'h0);
    rst_n = 1'b1;

    // Single request on ch0, len 3: 4-cycle pulse, busy 5 cycles
    len[5:0] = 6'd3;
    req = 4'b0001;
    tick();
    chk3("t1.pend", 4'b0000, 1'b0, 4'b0001);
    req = 4'b0000;
    tick();
    chk3("t1.grant", 4'b0001, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk3("t1.hold", 4'b0001, 1'b1, 4'b0000);
    end
    tick();
    chk3("t1.gap", 4'b0000, 1'b1, 4'b0000);
    tick();
    chk3("t1.idle", 4'b0000, 1'b0, 4'b0000);

    // Simultaneous 1011 with length 0, from reset pointer
    do_reset();
    len = '0;
    req = 4'b1011;
    tick();
    chk3("t2.pend", 4'b0000, 1'b0, 4'b1011);
    req = 4'b0000;
    tick();
    chk3("t2.ch0", 4'b0001, 1'b1, 4'b1010);
    tick();
    chk3("t2.lo0a", 4'b0000, 1'b1, 4'b1010);
    tick();
    chk3("t2.lo0b", 4'b0000, 1'b0, 4'b1010);
    tick();
    chk3("t2.ch1", 4'b0010, 1'b1, 4'b1000);
    tick();
    chk3("t2.lo1a", 4'b0000, 1'b1, 4'b1000);
    tick();
    chk3("t2.lo1b", 4'b0000, 1'b0, 4'b1000);
    tick();
    chk3("t2.ch3", 4'b1000, 1'b1, 4'b0000);
    tick();
    chk3("t2.lo3a", 4'b0000, 1'b1, 4'b0000);
    tick();
    chk3("t2.lo3b", 4'b0000, 1'b0, 4'b0000);

    // Wrap-around: ch2 served, then ch0 and ch2 pending together
    req = 4'b0100;
    tick();
    chk3("t3.pend2", 4'b0000, 1'b0, 4'b0100);
    req = 4'b0000;
    tick();
    chk3("t3.ch2", 4'b0100, 1'b1, 4'b0000);
    req = 4'b0101;
    tick();
    chk3("t3.both", 4'b0000, 1'b1, 4'b0101);
    req = 4'b0000;
    tick();
    chk3("t3.idle", 4'b0000, 1'b0, 4'b0101);
    tick();
    chk3("t3.ch0first", 4'b0001, 1'b1, 4'b0100);
    tick();
    tick();
    chk3("t3.idle2", 4'b0000, 1'b0, 4'b0100);
    tick();
    chk3("t3.ch2second", 4'b0100, 1'b1, 4'b0000);
    tick();
    tick();
    chk3("t3.done", 4'b0000, 1'b0, 4'b0000);

    // Overflow on ch1 while ch3 active
    len[23:18] = 6'd5;
    len[11:6]  = 6'd0;
    req = 4'b1000;
    tick();
    chk3("t4.pend3", 4'b0000, 1'b0, 4'b1000);
    req = 4'b0000;
    tick();
    chk3("t4.ch3", 4'b1000, 1'b1, 4'b0000);
    req = 4'b0010;
    tick();
    chk3("t4.req1a", 4'b1000, 1'b1, 4'b0010);
    chk("t4.ovf_a", 32'(ovf), 32'h0);
    tick();
    chk3("t4.req1b", 4'b1000, 1'b1, 4'b0010);
    chk("t4.ovf_b", 32'(ovf), 32'h2);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk3("t4.hold3", 4'b1000, 1'b1, 4'b0010);
    end
    tick();
    chk3("t4.gap", 4'b0000, 1'b1, 4'b0010);
    tick();
    chk3("t4.idle", 4'b0000, 1'b0, 4'b0010);
    tick();
    chk3("t4.ch1", 4'b0010, 1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4.noextra", 32'(pulse), 32'h0);
      chk("t4.pend0", 32'(pend), 32'h0);
    end
    chk("t4.ovf_sticky", 32'(ovf), 32'h2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4.ovf_clr", 32'(ovf), 32'h0);

    // Asynchronous reset mid-pulse with counter at 2 and ch1 pending
    len[5:0] = 6'd4;
    req = 4'b0001;
    tick();
    chk3("t5.pend0", 4'b0000, 1'b0, 4'b0001);
    req = 4'b0010;
    tick();
    chk3("t5.ch0", 4'b0001, 1'b1, 4'b0010);
    req = 4'b0000;
    tick();
    tick();
    chk3("t5.cnt2", 4'b0001, 1'b1, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk3("t5.async", 4'b0000, 1'b0, 4'b0000);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk3("t5.quiet", 4'b0000, 1'b0, 4'b0000);
    end

    // Second request on the active channel, len 5
    len[5:0] = 6'd5;
    req = 4'b0001;
    tick();
    chk3("t6.pend", 4'b0000, 1'b0, 4'b0001);
    for (int k = 1; k <= 16; k++) begin
      logic exp_p;
      req = (k == 4) ? 4'b0001 : 4'b0000;
      tick();
`ifdef BLASTER_PULSE_RETRIGGER_EN
      exp_p = (k >= 1 && k <= 9);
      if (k == 4) chk("t6.pend_retrig", 32'(pend), 32'h0);
`else
      exp_p = (k >= 1 && k <= 6) || (k >= 9 && k <= 14);
      if (k == 4) chk("t6.pend_queued", 32'(pend), 32'h1);
`endif
      chk($sformatf("t6.pulse_k%0d", k), 32'(pulse[0]), 32'(exp_p));
    end
    req = 4'b0000;
    chk("t6.ovf", 32'(ovf), 32'h0);
    chk3("t6.end", 4'b0000, 1'b0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
